// File: rtl/cycle_seq_pkg.sv
// cycle_seq_pkg: shared state, vector and width definitions for the cycle sequencer
package cycle_seq_pkg;
  localparam int TW = 3;
  typedef enum logic [1:0] {ST_INT, ST_FETCH, ST_EXEC} state_t;
  typedef enum logic [1:0] {VEC_NMI = 2'd0, VEC_RST = 2'd1, VEC_IRQ = 2'd2} vec_t;
endpackage

// File: rtl/cycle_seq_nmi_edge_det.sv
// nmi_edge_det: NMI rising-edge detector with a latch that holds the request until serviced
module nmi_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic nmi,
  input  logic clr,
  output logic nmi_pend
);
  logic nmi_prev, nmi_latch, nmi_edge;
  assign nmi_edge = nmi & ~nmi_prev;
  // a fresh edge counts toward the boundary decision in the same cycle it arrives
  assign nmi_pend = nmi_latch | nmi_edge;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      nmi_prev <= 1'b0;
      nmi_latch <= 1'b0;
    end else begin
      nmi_prev <= nmi;
      nmi_latch <= ~clr & nmi_pend;
    end
endmodule

// File: rtl/cycle_seq.sv
// cycle_seq: 6502 instruction-cycle sequencer (sync strobe, T-states, reset/NMI/IRQ sequences)
module cycle_seq
  import cycle_seq_pkg::*;
#(
  parameter int INT_CYCLES = 7,
  parameter int MAX_T = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  input  logic          op_done,
  input  logic          nmi,
  input  logic          irq,
  output logic          sync,
  output logic [TW-1:0] tstate,
  output logic          int_seq,
  output logic [1:0]    vec_sel,
  output logic          seq_err
);
  state_t state, nxt;
  logic [TW-1:0] t_nxt;
  logic [1:0] v_nxt;
  logic err_nxt, clr, nmi_pend, at_max, bnd;
  nmi_edge_det u_nmi (
    .clk(clk),
    .rst(rst),
    .nmi(nmi),
    .clr(clr),
    .nmi_pend(nmi_pend)
  );
  assign at_max = tstate == TW'(MAX_T);
  assign bnd = rdy && state == ST_EXEC && (op_done || at_max);
  always_comb begin
    nxt = state;
    t_nxt = tstate;
    v_nxt = vec_sel;
    err_nxt = seq_err;
    clr = 1'b0;
    if (bnd) begin
      nxt = (nmi_pend || irq) ? ST_INT : ST_FETCH;
      v_nxt = nmi_pend ? VEC_NMI : irq ? VEC_IRQ : vec_sel;
      clr = nmi_pend;
      t_nxt = '0;
      err_nxt = seq_err | ~op_done;
    end else if (rdy && state == ST_INT) begin
      nxt = (tstate == TW'(INT_CYCLES - 1)) ? ST_FETCH : ST_INT;
      t_nxt = (tstate == TW'(INT_CYCLES - 1)) ? '0 : tstate + TW'(1);
    end else if (rdy) begin
      nxt = ST_EXEC;
      t_nxt = tstate + TW'(1);
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_INT;
      tstate <= '0;
      int_seq <= 1'b1;
      vec_sel <= VEC_RST;
      sync <= 1'b0;
      seq_err <= 1'b0;
    end else begin
      state <= nxt;
      tstate <= t_nxt;
      int_seq <= nxt == ST_INT;
      vec_sel <= v_nxt;
      sync <= nxt == ST_FETCH;
      seq_err <= err_nxt;
    end
endmodule

// File: tb/tb_cycle_seq.sv
// tb_cycle_seq: directed self-checking bench for the cycle sequencer
module tb_cycle_seq;
  logic clk = 1'b0, rst, rdy, op_done, nmi, irq;
  logic sync, int_seq, seq_err;
  logic [2:0] tstate;
  logic [1:0] vec_sel;
  int checks = 0, errors = 0;

  cycle_seq dut (
    .clk(clk),
    .rst(rst),
    .rdy(rdy),
    .op_done(op_done),
    .nmi(nmi),
    .irq(irq),
    .sync(sync),
    .tstate(tstate),
    .int_seq(int_seq),
    .vec_sel(vec_sel),
    .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1; rdy = 1'b1; op_done = 1'b0; nmi = 1'b0; irq = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; op_done = 1'b0; nmi = 1'b0; irq = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({int_seq, vec_sel, tstate, sync, seq_err} !== {1'b1, 2'd1, 3'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: int_seq=%b vec=%0d t=%0d sync=%b err=%b, want 1 1 0 0 0", int_seq, vec_sel, tstate, sync, seq_err);
    end
    rst = 1'b0;
    for (int i = 1; i < 7; i++) begin
      @(negedge clk);
      checks++;
      if ({int_seq, vec_sel, tstate, sync} !== {1'b1, 2'd1, 3'(i), 1'b0}) begin
        errors++;
        $display("FAIL reset_seq_t%0d: int_seq=%b vec=%0d t=%0d sync=%b", i, int_seq, vec_sel, tstate, sync);
      end
    end
    @(negedge clk);
    checks++;
    if ({sync, tstate, int_seq} !== {1'b1, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_fetch: sync=%b t=%0d int_seq=%b, want 1 0 0", sync, tstate, int_seq);
    end
    @(negedge clk);
    checks++;
    if ({sync, tstate} !== {1'b0, 3'd1}) begin
      errors++;
      $display("FAIL reset_t1: sync=%b t=%0d, want 0 1", sync, tstate);
    end
  endtask

  task automatic test_basic();
    logic od [7] = '{0, 1, 0, 0, 0, 1, 0};
    logic es [7] = '{1, 0, 1, 0, 0, 0, 1};
    logic [2:0] et [7] = '{0, 1, 0, 1, 2, 3, 0};
    do_reset();
    for (int k = 0; k < 7; k++) begin
      checks++;
      if ({sync, tstate} !== {es[k], et[k]}) begin
        errors++;
        $display("FAIL basic_%0d: sync=%b t=%0d, want %b %0d", k, sync, tstate, es[k], et[k]);
      end
      op_done = od[k];
      @(negedge clk);
    end
    op_done = 1'b0;
  endtask

  task automatic test_nmi();
    do_reset();
    @(negedge clk);
    @(negedge clk);
    nmi = 1'b1;
    @(negedge clk);
    op_done = 1'b1;
    @(negedge clk);
    op_done = 1'b0;
    checks++;
    if ({int_seq, vec_sel, tstate} !== {1'b1, 2'd0, 3'd0}) begin
      errors++;
      $display("FAIL nmi_entry: int_seq=%b vec=%0d t=%0d, want 1 0 0", int_seq, vec_sel, tstate);
    end
    for (int i = 0; i < 7; i++) @(negedge clk);
    checks++;
    if ({sync, int_seq, vec_sel} !== {1'b1, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL nmi_exit: sync=%b int_seq=%b vec=%0d, want 1 0 0", sync, int_seq, vec_sel);
    end
    @(negedge clk);
    op_done = 1'b1;
    @(negedge clk);
    op_done = 1'b0;
    checks++;
    if ({sync, int_seq} !== {1'b1, 1'b0}) begin
      errors++;
      $display("FAIL nmi_once: sync=%b int_seq=%b, want 1 0", sync, int_seq);
    end
    nmi = 1'b0;
  endtask

  task automatic test_nmi_irq();
    do_reset();
    @(negedge clk);
    nmi = 1'b1; irq = 1'b1; op_done = 1'b1;
    @(negedge clk);
    op_done = 1'b0;
    checks++;
    if ({int_seq, vec_sel} !== {1'b1, 2'd0}) begin
      errors++;
      $display("FAIL prio_nmi: int_seq=%b vec=%0d, want 1 0", int_seq, vec_sel);
    end
    for (int i = 0; i < 8; i++) @(negedge clk);
    op_done = 1'b1;
    @(negedge clk);
    op_done = 1'b0;
    checks++;
    if ({int_seq, vec_sel, tstate} !== {1'b1, 2'd2, 3'd0}) begin
      errors++;
      $display("FAIL prio_irq: int_seq=%b vec=%0d t=%0d, want 1 2 0", int_seq, vec_sel, tstate);
    end
    irq = 1'b0; nmi = 1'b0;
  endtask

  task automatic test_stall();
    do_reset();
    @(negedge clk);
    @(negedge clk);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nmi = i >= 1;
      @(negedge clk);
      checks++;
      if ({tstate, sync} !== {3'd2, 1'b0}) begin
        errors++;
        $display("FAIL stall_%0d: t=%0d sync=%b, want 2 0", i, tstate, sync);
      end
    end
    rdy = 1'b1;
    @(negedge clk);
    checks++;
    if (tstate !== 3'd3) begin
      errors++;
      $display("FAIL stall_resume: t=%0d, want 3", tstate);
    end
    op_done = 1'b1;
    @(negedge clk);
    op_done = 1'b0;
    checks++;
    if ({int_seq, vec_sel} !== {1'b1, 2'd0}) begin
      errors++;
      $display("FAIL stall_nmi: int_seq=%b vec=%0d, want 1 0", int_seq, vec_sel);
    end
    nmi = 1'b0;
  endtask

  task automatic test_seq_err();
    do_reset();
    for (int i = 0; i < 7; i++) @(negedge clk);
    checks++;
    if (tstate !== 3'd7) begin
      errors++;
      $display("FAIL err_t7: t=%0d, want 7", tstate);
    end
    @(negedge clk);
    checks++;
    if ({sync, tstate, seq_err, int_seq} !== {1'b1, 3'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL err_set: sync=%b t=%0d err=%b int_seq=%b, want 1 0 1 0", sync, tstate, seq_err, int_seq);
    end
    @(negedge clk);
    op_done = 1'b1;
    @(negedge clk);
    op_done = 1'b0;
    @(negedge clk);
    checks++;
    if ({seq_err, tstate} !== {1'b1, 3'd1}) begin
      errors++;
      $display("FAIL err_sticky: err=%b t=%0d, want 1 1", seq_err, tstate);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({int_seq, tstate, vec_sel, seq_err, sync} !== {1'b1, 3'd0, 2'd1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_rst: int_seq=%b t=%0d vec=%0d err=%b sync=%b, want 1 0 1 0 0", int_seq, tstate, vec_sel, seq_err, sync);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_nmi();
    test_nmi_irq();
    test_stall();
    test_seq_err();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cycle_seq.md
Name: cycle_seq

Overview:
Instruction-cycle sequencer for the 6502 core. It generates the registered sync strobe that loads the instruction register and a per-instruction T-state counter. It also runs the forced 7-cycle reset/NMI/IRQ sequences and selects which interrupt vector is fetched. It sits between the bus controller (rdy) and the instruction decoder (op_done), and drives the IR load and the decode timing.

Parameters:
INT_CYCLES, 7, length of the reset/interrupt sequence in cycles (T0..T6)
MAX_T, 7, highest legal execute T-state; reaching it without op_done is a sequencing error

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-high reset
rdy  in  1  bus ready; 0 freezes all sequencer state this cycle
op_done  in  1  from decoder, combinational: current execute cycle is the instruction's last
nmi  in  1  NMI request, active-high level; rising edge is latched
irq  in  1  IRQ request, active-high level, already masked by the I flag upstream
sync  out  1  registered; 1 during the opcode-fetch cycle (IR load strobe)
tstate  out  3  current T-state within the instruction or interrupt sequence
int_seq  out  1  1 while a reset/NMI/IRQ sequence is running
vec_sel  out  2  vector select: 0=NMI (FFFA), 1=RESET (FFFC), 2=IRQ (FFFE); 3 is never driven
seq_err  out  1  sticky; set when tstate hits MAX_T without op_done

Behaviour:
- Reset:
  - rst=1 asynchronously forces state=INT, tstate=0, int_seq=1, vec_sel=1 (RESET), sync=0, seq_err=0, nmi_latch=0, nmi_prev=0.
  - First edge after rst deasserts runs the full reset sequence from T0.
  - rst mid-instruction or mid-sequence aborts it immediately.
- States: INT, FETCH, EXEC. All outputs are registered.
- Stall: with rdy=0, state, tstate, sync, int_seq, vec_sel and nmi_latch all hold. NMI edge detection still samples, so an edge during a stall is not lost.
- INT:
  - tstate counts 0..INT_CYCLES-1 with int_seq=1 and sync=0.
  - After T(INT_CYCLES-1) with rdy=1: go to FETCH, tstate=0, int_seq=0.
  - vec_sel stays constant for the whole sequence.
- FETCH (T0):
  - sync=1 for exactly one rdy=1 cycle; tstate=0.
  - Next state: EXEC with tstate=1.
  - op_done is ignored in FETCH.
- EXEC:
  - tstate increments each rdy=1 cycle.
  - op_done=1 with rdy=1 marks an instruction boundary. Next cycle:
    - NMI latched: INT with vec_sel=0; nmi_latch clears on entry.
    - else irq=1: INT with vec_sel=2.
    - else: FETCH.
  - Minimum instruction length is 2 cycles (T0, T1).
  - tstate==MAX_T with op_done=0 sets seq_err and forces the same boundary decision as op_done=1. The counter never wraps past MAX_T.
- NMI:
  - Latched on the rising edge of nmi: nmi & ~nmi_prev, where nmi_prev is registered every clk.
  - A held-high nmi produces one request only.
  - An edge arriving during an INT sequence (any vector) stays latched and is serviced at the next instruction boundary.
- Priority at a boundary: NMI > IRQ > fetch.
- IRQ: level-sensitive, sampled only at the boundary cycle; no latching.
- Simultaneous NMI edge and boundary in the same cycle: the edge counts as latched for that boundary decision (combinational OR of the new edge into the priority check).

Decomposition:
- Package cycle_seq_pkg: state encoding (INT/FETCH/EXEC), vec_sel codes (VEC_NMI=0, VEC_RST=1, VEC_IRQ=2), TW=3.
- One sub-module: nmi_edge_det. Contains the registered nmi_prev and the nmi_latch with set-on-edge and clear-on-service; it takes rst.

Test Plan:
- Reset release with rdy=1, op_done=0: int_seq=1, vec_sel=1, tstate 0..6 over 7 cycles. sync=1 on cycle 8 with tstate=0; cycle 9 tstate=1.
- After reset, op_done pulsed at T1, then at T3 of the next instruction: sync pattern 1,0,1,0,0,0,1 and tstate 0,1,0,1,2,3,0.
- NMI rising edge during T2 of a 4-cycle instruction (op_done at T3), nmi held high afterwards: INT entered with vec_sel=0 after T3. Exactly one NMI sequence; the next instruction boundary goes to FETCH.
- irq=1 and an NMI edge both present at the same boundary: vec_sel=0 sequence first. If irq is still 1 at the next boundary, a vec_sel=2 sequence follows.
- rdy=0 for 3 cycles at EXEC T2, with an NMI edge during the stall: tstate holds at 2 and sync holds at 0. Resumes at T3; NMI is taken at the next boundary.
- op_done held 0 through EXEC: seq_err=1 when tstate=7; next cycle sync=1; seq_err stays 1 until rst. rst asserted mid-EXEC immediately gives int_seq=1, tstate=0, vec_sel=1, seq_err=0.
